wb_counter_bank: RTL and testbench

WB_COUNTER_BANK -- requirements
Module: wb_counter_bank

---
 rtl/wb_counter_bank_pkg.sv | 30 +++
 rtl/counter_channel.sv | 111 +++++++++++
 rtl/wb_counter_bank.sv | 135 +++++++++++++
 tb/tb_wb_counter_bank.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_counter_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_counter_bank_pkg
// Purpose  : Register map, CTRL/STATUS bit positions and byte-lane helper
//            shared by the counter bank and its channels.
// Revision : 1.0
// ============================================================================
package wb_counter_bank_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_COUNT  = 2'd1,
        REG_RELOAD = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_DOWN   = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_IRQ_EN = 3;
    localparam int CTRL_W      = 4;

    localparam int STAT_WRAP   = 0;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_channel.sv
`default_nettype none
// ============================================================================
// Module   : counter_channel
// Purpose  : One up/down counter with reload value, control bits and a
//            sticky write-1-to-clear WRAP flag.
// Revision : 1.0
// ============================================================================
module counter_channel
    import wb_counter_bank_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              freeze_i,
    input  logic              wr_ctrl_i,
    input  logic              wr_count_i,
    input  logic              wr_reload_i,
    input  logic              wr_status_i,
    input  logic [31:0]       wdata_i,
    input  logic [31:0]       wmask_i,
    output logic [BITS-1:0]   count_o,
    output logic [BITS-1:0]   reload_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              wrap_o
);

    logic [BITS-1:0]   count_q, count_d;
    logic [BITS-1:0]   reload_q, reload_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              wrap_q, wrap_d;

    logic              w_tick;
    logic              w_wrap_evt;
    logic              w_w1c;
    logic [BITS-1:0]   w_count_nxt;
    logic [BITS-1:0]   w_dmask;
    logic [BITS-1:0]   w_wdata;
    logic              w_unused_ok;

    assign w_dmask = wmask_i[BITS-1:0];
    assign w_wdata = wdata_i[BITS-1:0];
    assign w_w1c   = wr_status_i & wdata_i[STAT_WRAP] & wmask_i[STAT_WRAP];
    assign w_tick  = ctrl_q[CTRL_EN] & ~freeze_i;

    always_comb begin
        w_count_nxt = count_q;
        w_wrap_evt  = 1'b0;
        if (ctrl_q[CTRL_DOWN]) begin
            if (count_q == '0) begin
                w_count_nxt = reload_q;
                w_wrap_evt  = w_tick;
            end else begin
                w_count_nxt = count_q - BITS'(1);
            end
        end else begin
            if (count_q == reload_q) begin
                w_count_nxt = '0;
                w_wrap_evt  = w_tick;
            end else begin
                w_count_nxt = count_q + BITS'(1);
            end
        end
        // A bus write to COUNT overrides the tick, so that tick cannot wrap.
        if (wr_count_i) begin
            w_wrap_evt = 1'b0;
        end
    end

    always_comb begin
        count_d  = w_tick ? w_count_nxt : count_q;
        reload_d = reload_q;
        ctrl_d   = ctrl_q;
        wrap_d   = w_wrap_evt | (wrap_q & ~w_w1c);
        if (w_wrap_evt & ctrl_q[CTRL_ONESHOT]) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end
        if (wr_count_i) begin
            count_d = (count_q & ~w_dmask) | (w_wdata & w_dmask);
        end
        if (wr_reload_i) begin
            reload_d = (reload_q & ~w_dmask) | (w_wdata & w_dmask);
        end
        if (wr_ctrl_i) begin
            ctrl_d = (ctrl_q & ~wmask_i[CTRL_W-1:0]) | (wdata_i[CTRL_W-1:0] & wmask_i[CTRL_W-1:0]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            reload_q <= '0;
            ctrl_q   <= '0;
            wrap_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            ctrl_q   <= ctrl_d;
            wrap_q   <= wrap_d;
        end
    end

    assign count_o  = count_q;
    assign reload_o = reload_q;
    assign ctrl_o   = ctrl_q;
    assign wrap_o   = wrap_q;

    assign w_unused_ok = &{1'b0, wdata_i, wmask_i};

endmodule
`default_nettype wire

// File: rtl/wb_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : wb_counter_bank
// Purpose  : Wishbone-classic slave exposing a bank of counter channels,
//            with interrupt, GPIO and logic-analyzer visibility of counts.
// Revision : 1.0
// ============================================================================
module wb_counter_bank
    import wb_counter_bank_pkg::*;
#(
    parameter int BITS     = 16,
    parameter int CHANNELS = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [127:0]    la_data_in,
    output logic [127:0]    la_data_out,
    input  logic [127:0]    la_oenb,
    output logic [BITS-1:0] io_out,
    output logic [BITS-1:0] io_oeb,
    output logic [2:0]      irq
);

    localparam int LA_CH = (CHANNELS < (128 / BITS)) ? CHANNELS : (128 / BITS);

    logic ack_q, ack_d;
    logic irq_q, irq_d;

    logic        w_valid;
    logic        w_wr;
    logic        w_freeze;
    logic [3:0]  w_chan;
    reg_sel_e    w_reg;
    logic [31:0] w_mask;
    logic [31:0] w_rdata;
    logic [127:0] w_la;
    logic        w_unused_ok;

    logic [BITS-1:0]   w_count  [CHANNELS];
    logic [BITS-1:0]   w_reload [CHANNELS];
    logic [CTRL_W-1:0] w_ctrl   [CHANNELS];
    logic [CHANNELS-1:0] w_wrap;
    logic [CHANNELS-1:0] w_irq_en;

    assign w_valid  = wbs_cyc_i & wbs_stb_i;
    assign ack_d    = w_valid & ~ack_q;
    // Writes land on the edge that ends the ack cycle.
    assign w_wr     = w_valid & wbs_we_i & ack_q;
    assign w_chan   = wbs_adr_i[7:4];
    assign w_reg    = reg_sel_e'(wbs_adr_i[3:2]);
    assign w_mask   = lane_mask(wbs_sel_i);
    assign w_freeze = ~la_oenb[64] & la_data_in[64];

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            logic w_hit;
            assign w_hit       = w_wr & (w_chan == 4'(c));
            assign w_irq_en[c] = w_ctrl[c][CTRL_IRQ_EN];

            counter_channel #(
                .BITS (BITS)
            ) u_chan (
                .clk_i       (wb_clk_i),
                .rst_ni      (wb_rst_i),
                .freeze_i    (w_freeze),
                .wr_ctrl_i   (w_hit & (w_reg == REG_CTRL)),
                .wr_count_i  (w_hit & (w_reg == REG_COUNT)),
                .wr_reload_i (w_hit & (w_reg == REG_RELOAD)),
                .wr_status_i (w_hit & (w_reg == REG_STATUS)),
                .wdata_i     (wbs_dat_i),
                .wmask_i     (w_mask),
                .count_o     (w_count[c]),
                .reload_o    (w_reload[c]),
                .ctrl_o      (w_ctrl[c]),
                .wrap_o      (w_wrap[c])
            );
        end
    endgenerate

    // Out-of-range channel indices match no entry and read back zero.
    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_chan == 4'(c)) begin
                case (w_reg)
                    REG_CTRL:   w_rdata = 32'(w_ctrl[c]);
                    REG_COUNT:  w_rdata = 32'(w_count[c]);
                    REG_RELOAD: w_rdata = 32'(w_reload[c]);
                    REG_STATUS: w_rdata = 32'(w_wrap[c]);
                    default:    w_rdata = '0;
                endcase
            end
        end
    end

    always_comb begin
        w_la = '0;
        for (int c = 0; c < LA_CH; c++) begin
            w_la[BITS*c +: BITS] = w_count[c];
        end
    end

    assign irq_d = |(w_wrap & w_irq_en);

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            irq_q <= irq_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = ack_q ? w_rdata : 32'h0;
    assign irq         = {2'b00, irq_q};
    assign io_out      = w_count[0];
    assign io_oeb      = {BITS{~wb_rst_i}};
    assign la_data_out = w_la;

    assign w_unused_ok = &{1'b0, wbs_adr_i[31:8], wbs_adr_i[1:0],
                           la_data_in[127:65], la_data_in[63:0],
                           la_oenb[127:65], la_oenb[63:0]};

endmodule
`default_nettype wire

// File: tb/tb_wb_counter_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_wb_counter_bank
// Purpose  : Directed scoreboard bench for wb_counter_bank.
// Revision : 1.0
// ============================================================================
module tb_wb_counter_bank;

    localparam int BITS     = 16;
    localparam int CHANNELS = 4;

    localparam int OBS_IO    = 0;
    localparam int OBS_OEB   = 1;
    localparam int OBS_IRQ   = 2;
    localparam int OBS_LA    = 3;
    localparam int OBS_ACK   = 4;
    localparam int OBS_LAALL = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]    sel = 4'h0;
    logic [31:0]   adr = 32'h0, wdat = 32'h0;
    logic          ack;
    logic [31:0]   rdat;
    logic [127:0]  la_in = '0, la_oenb = '1, la_out;
    logic [BITS-1:0] io_out, io_oeb;
    logic [2:0]    irq;

    always #5 clk = ~clk;

    wb_counter_bank #(
        .BITS     (BITS),
        .CHANNELS (CHANNELS)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_dat_i   (wdat),
        .wbs_adr_i   (adr),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .la_data_in  (la_in),
        .la_data_out (la_out),
        .la_oenb     (la_oenb),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .irq         (irq)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_t;

    typedef struct {
        string        name;
        int           src;
        int           ch;
        logic [127:0] exp;
    } obs_t;

    rd_t  rd_q[$];
    obs_t obs_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    rd_t          m_r;
    obs_t         m_o;
    logic [127:0] m_act;

    // Monitor: bus reads are checked on ack, probe expectations on the next falling edge.
    always @(negedge clk) begin
        if (ack && !we) begin
            n_tests++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read_ack: got data %h, required no ack", rdat);
            end else begin
                m_r = rd_q.pop_front();
                if (rdat !== m_r.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h, required %h", m_r.name, rdat, m_r.exp);
                end
            end
        end
        while (obs_q.size() > 0) begin
            m_o = obs_q.pop_front();
            case (m_o.src)
                OBS_IO:  m_act = 128'(io_out);
                OBS_OEB: m_act = 128'(io_oeb);
                OBS_IRQ: m_act = 128'(irq);
                OBS_LA:  m_act = 128'(la_out[BITS*m_o.ch +: BITS]);
                OBS_ACK: m_act = 128'(ack);
                default: m_act = la_out;
            endcase
            n_tests++;
            if (m_act !== m_o.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, required %h", m_o.name, m_act, m_o.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic obs(input string name, input int src, input int ch, input logic [127:0] exp);
        obs_t o;
        o.name = name;
        o.src  = src;
        o.ch   = ch;
        o.exp  = exp;
        obs_q.push_back(o);
    endtask

    task automatic wait_ack(input logic [31:0] a);
        int k;
        k = 0;
        while (!ack && k < 8) begin
            step();
            k++;
        end
        if (!ack) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: adr %h got no ack, required ack within 8 cycles", a);
        end
    endtask

    // Returns one tick after the commit edge of the transfer.
    task automatic wb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        step();
        cyc = 1'b1; stb = 1'b1; we = wr; adr = a; wdat = d; sel = s;
        wait_ack(a);
        step();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wb_xfer(1'b1, a, d, 4'hF);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        rd_t r;
        r.name = name;
        r.exp  = exp;
        rd_q.push_back(r);
        wb_xfer(1'b0, a, 32'h0, 4'hF);
    endtask

    logic [15:0] seq_up   [5] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
    logic [15:0] seq_down [5] = '{16'd1, 16'd0, 16'd2, 16'd2, 16'd2};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        obs("rst_oeb", OBS_OEB, 0, 128'hFFFF);
        obs("rst_ack", OBS_ACK, 0, 128'h0);
        obs("rst_irq", OBS_IRQ, 0, 128'h0);
        obs("rst_la",  OBS_LAALL, 0, 128'h0);
        step();
        rst_n = 1'b1;
        step();
        obs("run_oeb", OBS_OEB, 0, 128'h0);
        rd("rst_ch0_count",  32'h04, 32'h0);
        rd("rst_ch0_reload", 32'h08, 32'h0);
        rd("rst_ch0_ctrl",   32'h00, 32'h0);

        // ch0 up-count wrapping at RELOAD=3
        wr(32'h08, 32'd3);
        wr(32'h00, 32'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            obs("ch0_up_seq", OBS_IO, 0, 128'(seq_up[i]));
        end
        rd("ch0_wrap", 32'h0C, 32'h1);
        wr(32'h00, 32'h0);

        // ch1 oneshot down-count from 2
        wr(32'h18, 32'd2);
        wr(32'h14, 32'd2);
        wr(32'h10, 32'h7);
        for (int i = 0; i < 5; i++) begin
            step();
            obs("ch1_down_seq", OBS_LA, 1, 128'(seq_down[i]));
        end
        rd("ch1_ctrl_en_cleared", 32'h10, 32'h6);
        rd("ch1_wrap",            32'h1C, 32'h1);
        rd("ch1_count_held",      32'h14, 32'h2);

        // ch2 interrupt timing
        wr(32'h28, 32'd1);
        wr(32'h20, 32'h9);
        step();
        obs("ch2_irq_c1", OBS_IRQ, 0, 128'h0);
        obs("ch2_cnt_c1", OBS_LA, 2, 128'h1);
        step();
        obs("ch2_irq_at_wrap", OBS_IRQ, 0, 128'h0);
        obs("ch2_cnt_wrap", OBS_LA, 2, 128'h0);
        step();
        obs("ch2_irq_rise", OBS_IRQ, 0, 128'h1);
        wr(32'h20, 32'h8);
        obs("ch2_irq_stopped", OBS_IRQ, 0, 128'h1);
        wr(32'h2C, 32'h1);
        obs("ch2_irq_w1c_edge", OBS_IRQ, 0, 128'h1);
        step();
        obs("ch2_irq_drop", OBS_IRQ, 0, 128'h0);
        rd("ch2_wrap_cleared", 32'h2C, 32'h0);

        // COUNT write collides with a tick on ch0
        wr(32'h08, 32'hFFFF);
        wr(32'h00, 32'h1);
        wr(32'h04, 32'h55);
        obs("ch0_write_wins", OBS_IO, 0, 128'h55);
        step();
        obs("ch0_after_write", OBS_IO, 0, 128'h56);
        step();
        obs("ch0_after_write2", OBS_IO, 0, 128'h57);
        wr(32'h00, 32'h0);

        // byte lanes and truncation on ch3
        wb_xfer(1'b1, 32'h38, 32'h0000ABCD, 4'b0001);
        rd("ch3_reload_lane0", 32'h38, 32'h00CD);
        wb_xfer(1'b1, 32'h38, 32'h00001234, 4'b0010);
        rd("ch3_reload_lane1", 32'h38, 32'h12CD);
        wr(32'h34, 32'hFFFF1234);
        rd("ch3_count_trunc", 32'h34, 32'h1234);
        wr(32'h30, 32'hFFFFFFF0);
        rd("ch3_ctrl_hi_zero", 32'h30, 32'h0);

        // channel 9 is outside the bank
        rd("ch9_count", 32'h94, 32'h0);
        wr(32'h94, 32'h77);
        wr(32'h90, 32'hF);
        rd("ch9_ctrl", 32'h90, 32'h0);
        rd("ch1_count_untouched", 32'h14, 32'h2);
        rd("ch1_ctrl_untouched",  32'h10, 32'h6);

        // freeze through LA bit 64
        la_oenb[64] = 1'b0;
        la_in[64]   = 1'b1;
        wr(32'h30, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            obs("ch3_frozen", OBS_LA, 3, 128'h1234);
        end
        rd("ch3_frozen_read", 32'h34, 32'h1234);
        la_oenb[64] = 1'b1;
        step();
        obs("ch3_unfrozen1", OBS_LA, 3, 128'h1235);
        step();
        obs("ch3_unfrozen2", OBS_LA, 3, 128'h1236);
        la_oenb[64] = 1'b0;
        step();
        obs("ch3_refrozen1", OBS_LA, 3, 128'h1236);
        step();
        obs("ch3_refrozen2", OBS_LA, 3, 128'h1236);

        // reset asserted while a write is being acknowledged
        step();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h28; wdat = 32'h44; sel = 4'hF;
        wait_ack(32'h28);
        #1;
        rst_n = 1'b0;
        obs("mid_rst_ack", OBS_ACK, 0, 128'h0);
        obs("mid_rst_oeb", OBS_OEB, 0, 128'hFFFF);
        obs("mid_rst_io",  OBS_IO,  0, 128'h0);
        obs("mid_rst_la",  OBS_LAALL, 0, 128'h0);
        obs("mid_rst_irq", OBS_IRQ, 0, 128'h0);
        step();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        obs("post_rst_oeb", OBS_OEB, 0, 128'h0);
        obs("post_rst_la",  OBS_LAALL, 0, 128'h0);
        rd("post_rst_ch2_reload", 32'h28, 32'h0);
        rd("post_rst_ch3_ctrl",   32'h30, 32'h0);
        rd("post_rst_ch1_status", 32'h1C, 32'h0);
        rd("post_rst_ch3_count",  32'h34, 32'h0);

        repeat (4) step();
        if (rd_q.size() != 0 || obs_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d reads and %0d probes pending, required 0",
                     rd_q.size(), obs_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200us, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
